// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between NUM_REQ requesters,
// with a one-entry registered response returned to the owner by valid/ready.
`ifndef WORD_SIZE_B
`define WORD_SIZE_B 4
`endif

module alu_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int WORD_SIZE_B = `WORD_SIZE_B,
  parameter int CTRL_W      = 4,
  localparam int W          = 8 * WORD_SIZE_B,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*W-1:0]      req_rs1,
  input  logic [NUM_REQ*W-1:0]      req_rs2,
  input  logic [NUM_REQ*CTRL_W-1:0] req_control,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [W-1:0]              resp_rd,
  output logic [W-1:0]              alu_rs1,
  output logic [W-1:0]              alu_rs2,
  output logic [CTRL_W-1:0]         alu_control,
  input  logic [W-1:0]              alu_rd,
  output logic                      busy
);

  logic             resp_pending;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;

  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic             accept_ok;
  logic             accept;

  // Stage p0: round-robin grant and alu operand steering (combinational)
  always_comb begin
    cand      = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign accept_ok = !resp_pending || resp_ready[owner];
  assign accept    = grant_any && accept_ok;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  assign alu_rs1     = grant_any ? req_rs1[int'(grant_idx)*W +: W] : '0;
  assign alu_rs2     = grant_any ? req_rs2[int'(grant_idx)*W +: W] : '0;
  assign alu_control = grant_any ? req_control[int'(grant_idx)*CTRL_W +: CTRL_W] : '0;

  // Stage p1: one-entry response register; a retire and a new accept may share an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_pending <= 1'b0;
      owner        <= '0;
      rr_ptr       <= '0;
      resp_rd      <= '0;
    end else if (accept) begin
      resp_pending <= 1'b1;
      owner        <= grant_idx;
      resp_rd      <= alu_rd;
      rr_ptr       <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end else if (resp_pending && resp_ready[owner]) begin
      resp_pending <= 1'b0;
    end
  end

  assign resp_valid = resp_pending ? (NUM_REQ'(1) << owner) : '0;
  assign busy       = resp_pending;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational alu instance between NUM_REQ requesters, e.g. the execute stage and a multi-cycle address/loop unit.
- Arbitrates with round-robin priority and drives the alu operand and control inputs from the granted requester.
- Captures alu rd into a one-entry response register.
- Returns the result to the owning requester over a valid/ready handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WORD_SIZE_B, `WORD_SIZE_B (4), word size in bytes; W = 8*WORD_SIZE_B.
- CTRL_W, 4, alu control field width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted this cycle (one-hot or zero).
- req_rs1  in  NUM_REQ*W  flattened operand 1; requester i uses bits [i*W +: W].
- req_rs2  in  NUM_REQ*W  flattened operand 2.
- req_control  in  NUM_REQ*CTRL_W  flattened alu control.
- resp_valid  out  NUM_REQ  one-hot; the bit of the owner is set while a result is pending.
- resp_ready  in  NUM_REQ  per-requester response ready.
- resp_rd  out  W  registered result.
- alu_rs1  out  W  to alu rs1.
- alu_rs2  out  W  to alu rs2.
- alu_control  out  CTRL_W  to alu control.
- alu_rd  in  W  from alu rd.
- busy  out  1  high when a response is pending.

Behaviour:
- State: resp_pending (1 bit), owner (index), rr_ptr (index), resp_rd.
- Reset values: all of the above 0; resp_valid = 0; busy = 0.
- Reset is asynchronous. Asserting it mid-transaction drops the pending response with no further handshake.

Accept condition:
- accept_ok = !resp_pending || resp_ready[owner].
- Back-to-back operation is allowed: a response can retire and a new request be accepted in the same cycle, giving one operation per cycle sustained.

Grant:
- Combinational round-robin over req_valid.
- Search starts at rr_ptr, increments modulo NUM_REQ, and stops at the first valid.
- grant is one-hot, or zero if no request is valid.
- req_ready = grant when accept_ok, else all zeros.

Alu drive:
- When a requester is granted, alu_rs1, alu_rs2 and alu_control come from that requester's slices.
- Otherwise all three are driven to 0.
- The alu is combinational (control 0000 = add, wrapping modulo 2^W; any other code gives 0). The arbiter does not interpret control and passes it through unchanged.

On accept of requester i (rising edge):
- resp_rd <= alu_rd.
- owner <= i.
- resp_pending <= 1.
- rr_ptr <= (i+1) mod NUM_REQ.

Response retire:
- The response retires when resp_pending && resp_ready[owner] with no new accept; then resp_pending <= 0.
- resp_rd holds its value until it is overwritten.

Timing:
- Latency is 1: the request is accepted at edge N, and resp_valid[owner] and resp_rd are valid after edge N.
- resp_valid[k] = resp_pending && (owner == k).
- busy = resp_pending.
- resp_ready of non-owners is ignored.

Requester obligations:
- rs1, rs2 and control must stay stable while valid && !ready.
- valid must not be dropped before ready. The arbiter does not check this.

Boundary cases:
- Pending response with owner not ready: all req_ready stay 0 and rr_ptr is unchanged (backpressure).
- A single requester valid every cycle is granted every cycle, as long as its response is consumed.
- Simultaneous requests from all NUM_REQ requesters: each is served once per NUM_REQ accepts, so no starvation.
- rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
1. Reset then single add: assert rst mid-run, then release. Req0 sends rs1=0x00000005, rs2=0x00000003, ctl=0000, with resp_ready high. Expected: req_ready[0]=1 at the accept edge; the next cycle has resp_valid=01 and resp_rd=0x00000008; busy drops after the retire.
2. Wrap and unsupported code: rs1=0xFFFFFFFF, rs2=0x00000002, ctl=0000 -> resp_rd=0x00000001. Then ctl=0101 -> resp_rd=0x00000000.
3. Contention: both requesters hold valid continuously with resp_ready high. Expected grants 0,1,0,1 on consecutive cycles; each resp_valid goes to the correct owner with the matching sum; throughput is 1 per cycle.
4. Backpressure: req1 is accepted, then resp_ready[1]=0 for 3 cycles while req0 is valid. Expected: req_ready=00 and resp_rd is stable for those 3 cycles. When resp_ready[1] rises, req0 is accepted on the same edge.
5. Async reset mid-operation: assert rst between clock edges while resp_pending=1. Expected: resp_valid=0, busy=0 and resp_rd=0 immediately, without waiting for a clock edge; after release, the first grant goes to req0.
